// File: rtl/sevenseg_scan_scheduler.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_scheduler
//
// Purpose
//   Time-multiplexes one active-low 7-segment bus across NUM_DIGITS
//   common-anode digits. New hex values and blink masks are written into a
//   single-entry pending buffer. That buffer is copied to the display
//   registers only at a frame boundary, so a frame never mixes old and new
//   digits. Digits that are set in the blink mask flash from one shared blink
//   phase, so all blinking digits stay in step.
//
// Build option
//   SEVENSEG_GHOST_BLANK_EN : when defined, every digit drive period is
//   followed by BLANK_CYCLES cycles with all digits and segments off. This
//   suppresses ghosting on slow digit drivers. When undefined, digits are
//   driven back-to-back and BLANK_CYCLES has no effect.
//
// Ports
//   iClk        in   clock, rising edge
//   nRst        in   asynchronous reset, active-low
//   iValue      in   4*NUM_DIGITS hex nibbles; digit k = iValue[4k+3:4k]
//   iBlinkMask  in   NUM_DIGITS; 1 = digit k blinks
//   iLoad       in   write strobe
//   oReady      out  pending buffer empty
//   oDigitSel   out  active-low digit enables; at most one bit is low
//   oSeg        out  active-low segments {g,f,e,d,c,b,a}
//   oFrameTick  out  1-cycle pulse when digit 0 is shown again after a wrap
//
// Handshake
//   A write is accepted on any rising edge where iLoad && oReady. oReady
//   then stays low until the frame boundary that moves the pending entry into
//   the display registers, and it rises in the cycle after that boundary.
//   iLoad while oReady is low is dropped; there is no queueing.
//
// Parameters SCAN_DIV, BLINK_DIV and BLANK_CYCLES must each be at least 1.
// ---------------------------------------------------------------------------
module sevenseg_scan_scheduler #(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [31:0] SCAN_DIV     = 32'd50_000,
    parameter logic [31:0] BLINK_DIV    = 32'd25_000_000,
    parameter logic [15:0] BLANK_CYCLES = 16'd500
) (
    input  logic                    iClk,
    input  logic                    nRst,
    input  logic [4*NUM_DIGITS-1:0] iValue,
    input  logic [NUM_DIGITS-1:0]   iBlinkMask,
    input  logic                    iLoad,
    output logic                    oReady,
    output logic [NUM_DIGITS-1:0]   oDigitSel,
    output logic [6:0]              oSeg,
    output logic                    oFrameTick
);

    localparam int              IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Scan and blink state
    logic [IDX_W-1:0]        r_idx;
    logic [31:0]             r_scan_cnt;
    logic [31:0]             r_blink_cnt;
    logic                    r_blink_off;

    // Display and pending buffers
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_mask;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_mask;
    logic                    r_pend_full;

    // Registered outputs
    logic                    r_wrapped;
    logic [NUM_DIGITS-1:0]   r_digit_sel;
    logic [6:0]              r_seg;
    logic                    r_frame_tick;

    // Combinational control
    logic                    w_cnt_clr;   // scan counter restarts next cycle
    logic                    w_step;      // index advances to the next digit
    logic                    w_driving;   // a digit is being driven (not blanked)
    logic                    w_boundary;
    logic                    w_accept;
    logic                    w_blink_end;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg_dec;
    logic [6:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_sel_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

`ifdef SEVENSEG_GHOST_BLANK_EN
    // Drive/blank sequencer. r_state is the observable sequencer state.
    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_t;

    scan_state_t r_state;
    scan_state_t w_state_nxt;

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_DRIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The scan counter is shared: it times the drive period in ST_DRIVE and
    // the blanking gap in ST_BLANK. The index only moves when blanking ends.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_step      = 1'b0;
        w_driving   = 1'b1;
        case (r_state)
            ST_DRIVE: begin
                if (r_scan_cnt == SCAN_DIV - 32'd1) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_BLANK: begin
                w_driving = 1'b0;
                if (r_scan_cnt == {16'd0, BLANK_CYCLES} - 32'd1) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_clr   = 1'b1;
                    w_step      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_DRIVE;
            end
        endcase
    end
`else
    logic w_unused_blank;
    assign w_unused_blank = ^BLANK_CYCLES;

    always_comb begin
        w_cnt_clr = (r_scan_cnt == SCAN_DIV - 32'd1);
        w_step    = w_cnt_clr;
        w_driving = 1'b1;
    end
`endif

    always_comb begin
        w_boundary  = w_step && (r_idx == LAST_IDX);
        w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        w_accept    = iLoad && !r_pend_full;
        w_blink_end = (r_blink_cnt == BLINK_DIV - 32'd1);
        w_nibble    = r_disp_val[{r_idx, 2'b00} +: 4];
        w_seg_dec   = hex_to_seg(w_nibble);

        // Next output values come from the current index/data, so the pins
        // lag the internal index by one cycle.
        w_sel_nxt = '1;
        w_seg_nxt = 7'h7F;
        if (w_driving) begin
            w_sel_nxt = ~(NUM_DIGITS'(1) << r_idx);
            if (!(r_disp_mask[r_idx] && r_blink_off)) begin
                w_seg_nxt = w_seg_dec;
            end
        end
    end

    // Scan index and counter
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_scan_cnt <= w_cnt_clr ? 32'd0 : r_scan_cnt + 32'd1;
            if (w_step) begin
                r_idx <= w_idx_nxt;
            end
        end
    end

    // Blink timebase runs regardless of the mask so every blinking digit
    // shares the same phase.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (w_blink_end) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + 32'd1;
        end
    end

    // Pending buffer and display registers. Apply needs a full buffer and
    // accept needs an empty one, so the two never happen in the same cycle;
    // a write landing on a boundary cycle waits for the next boundary.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_pend_val  <= '0;
            r_pend_mask <= '0;
            r_pend_full <= 1'b0;
            r_disp_val  <= '0;
            r_disp_mask <= '0;
        end else if (w_boundary && r_pend_full) begin
            r_disp_val  <= r_pend_val;
            r_disp_mask <= r_pend_mask;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend_val  <= iValue;
            r_pend_mask <= iBlinkMask;
            r_pend_full <= 1'b1;
        end
    end

    // Output registers. r_wrapped delays the boundary by one cycle so the
    // frame tick lines up with oDigitSel first showing digit 0.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_wrapped    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_digit_sel  <= '1;
            r_seg        <= 7'h7F;
        end else begin
            r_wrapped    <= w_boundary;
            r_frame_tick <= r_wrapped;
            r_digit_sel  <= w_sel_nxt;
            r_seg        <= w_seg_nxt;
        end
    end

    assign oReady     = ~r_pend_full;
    assign oDigitSel  = r_digit_sel;
    assign oSeg       = r_seg;
    assign oFrameTick = r_frame_tick;

endmodule
